// File: rtl/pixel_feed_ctrl.sv
// Streams (S, north-east) sample pairs from a linearly addressed sample RAM
// into the predictor front-end, scanning x fastest, then z, then y.
module pixel_feed_ctrl #(
  parameter int X_LEN      = 11,
  parameter int Y_LEN      = 5,
  parameter int Z_LEN      = 8,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [X_LEN-1:0]      Nx,
  input  logic [Y_LEN-1:0]      Ny,
  input  logic [Z_LEN-1:0]      Nz,
  input  logic                  ready_i,
  output logic                  ram_a_re_o,
  output logic [ADDR_W-1:0]     ram_a_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_a_data_i,
  output logic                  ram_b_re_o,
  output logic [ADDR_W-1:0]     ram_b_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_b_data_i,
  output logic [31:0]           data_o,
  output logic                  en_o,
  output logic [X_LEN-1:0]      Nx_o,
  output logic [Y_LEN-1:0]      Ny_o,
  output logic [Z_LEN-1:0]      Nz_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [X_LEN-1:0]  r_nx, r_x;
  logic [Y_LEN-1:0]  r_ny, r_y;
  logic [Z_LEN-1:0]  r_nz, r_z;
  logic [ADDR_W-1:0] r_addr, r_stride;
  logic              r_inflight, r_tag_y0;
  logic [31:0]       r_q0, r_q1;
  logic [1:0]        r_cnt;

  logic              w_accept, w_pop, w_issue;
  logic              w_x_last, w_y_last, w_z_last, w_last;
  logic [2:0]        w_occ;
  logic [15:0]       w_s16, w_sne16;
  logic [31:0]       w_word;

  assign w_accept = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_x_last = (r_x == r_nx - X_LEN'(1));
  assign w_y_last = (r_y == r_ny - Y_LEN'(1));
  assign w_z_last = (r_z == r_nz - Z_LEN'(1));
  assign w_last   = w_x_last && w_y_last && w_z_last;

  assign en_o  = (r_cnt != 2'd0);
  assign w_pop = en_o && ready_i;
  // A head word leaving this cycle frees its slot, which keeps one word per cycle.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (w_occ < 3'd2);

  assign ram_a_re_o   = w_issue;
  assign ram_a_addr_o = r_addr;
  assign ram_b_re_o   = w_issue && (r_y != '0);
  assign ram_b_addr_o = ram_b_re_o ?
                        (r_addr - r_stride + {{(ADDR_W-1){1'b0}}, ~w_x_last}) : '0;

  assign w_s16   = 16'(ram_a_data_i);
  assign w_sne16 = r_tag_y0 ? 16'd0 : 16'(ram_b_data_i);
  assign w_word  = {w_sne16, w_s16};

  assign data_o = r_q0;
  assign Nx_o   = r_nx;
  assign Ny_o   = r_ny;
  assign Nz_o   = r_nz;
  assign busy_o = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_RUN;
      S_RUN:   if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_inflight && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)))
                 w_next = S_DONE;
      S_DONE:  w_next = start_i ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Geometry latch and scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nx <= '0; r_ny <= '0; r_nz <= '0; r_stride <= '0;
      r_x  <= '0; r_y  <= '0; r_z  <= '0; r_addr   <= '0;
      r_inflight <= 1'b0;
      r_tag_y0   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_tag_y0   <= w_issue && (r_y == '0);
      if (w_accept) begin
        r_nx     <= Nx;
        r_ny     <= Ny;
        r_nz     <= Nz;
        r_stride <= ADDR_W'(Nx) * ADDR_W'(Nz);
        r_x <= '0; r_y <= '0; r_z <= '0; r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (w_x_last) begin
          r_x <= '0;
          if (w_z_last) begin
            r_z <= '0;
            r_y <= r_y + Y_LEN'(1);
          end else begin
            r_z <= r_z + Z_LEN'(1);
          end
        end else begin
          r_x <= r_x + X_LEN'(1);
        end
      end
    end
  end

  // Two-entry output queue; r_q0 is always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= w_word;
          else               r_q1 <= w_word;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_q1  <= '0;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_q0 <= r_q1;
            r_q1 <= w_word;
          end else begin
            r_q0 <= w_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
